// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared types and constants for the UART receive/transmit path.
//             Holds the receiver state enum, line-level constants for start
//             and stop bits, frame geometry and a 3-sample majority helper.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam int   DATA_BITS  = 8;
    localparam int   OVERSAMPLE = 16;

    // Bit value when at least two of the three mid-bit samples agree.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
//  Module   : uart_baud_tick
//  Purpose  : Oversampling prescaler. Emits a one-clock tick every
//             DIV = CLK_FRQ/(BAUD_RATE*OVERSAMPLE) clocks. A restart pulse
//             zeroes the counter so the first tick lands DIV clocks later,
//             which aligns the tick grid to a detected start edge.
//  Ports    : clk      - system clock
//             areset_n - asynchronous active-low reset
//             restart  - zero the divider this clock
//             tick     - one-clock pulse at the oversample rate
//  Revision : 1.0  initial release
// ============================================================================
module uart_baud_tick #(
    parameter int CLK_FRQ    = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic areset_n,
    input  logic restart,
    output logic tick
);

    localparam int                 c_DIV   = CLK_FRQ / (BAUD_RATE * OVERSAMPLE);
    // Keep at least one counter bit so a divide-by-one build still elaborates.
    localparam int                 c_CNT_W = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(c_DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_cnt <= '0;
        end else if (restart || (r_cnt == c_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == c_LAST);

endmodule : uart_baud_tick
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : 8N1 serial receiver. Synchronises the line, oversamples each
//             bit 16x, decides each bit by majority of samples 7/8/9 and
//             presents bytes over a valid/ack handshake with framing and
//             overrun error pulses.
//  Ports    : clk       - system clock
//             areset_n  - asynchronous active-low reset
//             data_in   - asynchronous serial line, idle high
//             data_out  - last accepted byte, held until the next one
//             rx_valid  - data_out not yet consumed
//             rx_ack    - consumer takes data_out (only while rx_valid)
//             rx_busy   - receiver outside IDLE
//             frame_err - one-clock pulse on a low stop bit
//             overrun   - one-clock pulse when a good byte meets rx_valid=1
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx #(
    parameter int CLK_FRQ    = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    // Phase counter is 4 bits wide; only 16x oversampling is supported.
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       areset_n,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun
);

    import uart_pkg::*;

    localparam logic [3:0] c_PH_S7  = 4'd7;
    localparam logic [3:0] c_PH_S8  = 4'd8;
    localparam logic [3:0] c_PH_DEC = 4'd9;
    localparam logic [3:0] c_PH_WRAP = 4'd0;
    localparam logic [2:0] c_LAST_BIT = 3'(DATA_BITS - 1);

    // ------------------------------------------------------------------
    // Line synchroniser and edge register (all idle high)
    // ------------------------------------------------------------------
    logic r_sync1;
    logic r_rx_s;
    logic r_rx_d;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
            r_rx_d  <= 1'b1;
        end else begin
            r_sync1 <= data_in;
            r_rx_s  <= r_sync1;
            r_rx_d  <= r_rx_s;
        end
    end

    // ------------------------------------------------------------------
    // Receiver state
    // ------------------------------------------------------------------
    rx_state_t            r_state;
    logic [3:0]           r_ph;
    logic                 r_samp7;
    logic                 r_samp8;
    logic [2:0]           r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [7:0]           r_data_out;
    logic                 r_valid;
    logic                 r_busy;
    logic                 r_frame_err;
    logic                 r_overrun;

    logic       w_tick;
    logic       w_start_edge;
    logic [3:0] w_ph_next;
    logic       w_bit;

    assign w_start_edge = (r_state == IDLE) && (r_rx_s == START_BIT) && (r_rx_d == STOP_BIT);
    assign w_ph_next    = r_ph + 4'd1;
    // The third sample is the live synchronised line on the ph=9 tick.
    assign w_bit        = majority3(r_samp7, r_samp8, r_rx_s);

    uart_baud_tick #(
        .CLK_FRQ    (CLK_FRQ),
        .BAUD_RATE  (BAUD_RATE),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_baud_tick (
        .clk      (clk),
        .areset_n (areset_n),
        .restart  (w_start_edge),
        .tick     (w_tick)
    );

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_state     <= IDLE;
            r_ph        <= '0;
            r_samp7     <= 1'b0;
            r_samp8     <= 1'b0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_data_out  <= '0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;

            // Ack clears valid; a coincident good-stop load below overrides it.
            if (rx_ack && r_valid) begin
                r_valid <= 1'b0;
            end

            // Phase tracking and sample capture are common to every active state.
            if ((r_state != IDLE) && w_tick) begin
                r_ph <= w_ph_next;
                if (w_ph_next == c_PH_S7) begin
                    r_samp7 <= r_rx_s;
                end
                if (w_ph_next == c_PH_S8) begin
                    r_samp8 <= r_rx_s;
                end
            end

            case (r_state)
                IDLE: begin
                    if (w_start_edge) begin
                        r_ph    <= '0;
                        r_state <= START;
                        r_busy  <= 1'b1;
                    end
                end

                START: begin
                    if (w_tick) begin
                        if ((w_ph_next == c_PH_DEC) && (w_bit != START_BIT)) begin
                            // False start: return quietly.
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else if (w_ph_next == c_PH_WRAP) begin
                            r_state   <= DATA;
                            r_bit_cnt <= '0;
                        end
                    end
                end

                DATA: begin
                    if (w_tick) begin
                        if (w_ph_next == c_PH_DEC) begin
                            r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
                        end else if (w_ph_next == c_PH_WRAP) begin
                            if (r_bit_cnt == c_LAST_BIT) begin
                                r_state <= STOP;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                            end
                        end
                    end
                end

                STOP: begin
                    // Leave on the decision tick so a following start edge
                    // that arrives early in the stop bit is not missed.
                    if (w_tick && (w_ph_next == c_PH_DEC)) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        if (w_bit == STOP_BIT) begin
                            if (r_valid && !rx_ack) begin
                                r_overrun <= 1'b1;
                            end else begin
                                r_data_out <= r_shift;
                                r_valid    <= 1'b1;
                            end
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out  = r_data_out;
    assign rx_valid  = r_valid;
    assign rx_busy   = r_busy;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Purpose  : Directed plus randomised bench for uart_rx. A bit-level line
//             generator plays the transmit stage; expected byte, valid and
//             error outcomes come from a frame-level model of the handshake.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx;

    localparam int CLK_FRQ   = 50_000_000;
    localparam int BAUD_RATE = 115_200;
    localparam int DIV       = CLK_FRQ / (BAUD_RATE * 16);   // 27
    localparam int BITCLK    = 16 * DIV;                     // clocks per bit
    // Line falls just after edge 0; detection acts on edge 3; the stop
    // decision edge is 153 ticks later. Loop step c ends on edge c+1.
    localparam int DEC_C     = 3 + 153 * DIV - 1;
    localparam int FALSE_C   = 3 + 9 * DIV - 1;

    logic       clk = 1'b0;
    logic       areset_n;
    logic       data_in;
    logic       rx_ack;
    logic [7:0] data_out;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun;

    int         checks = 0;
    int         errors = 0;

    // Frame-level model of what the consumer should see.
    logic       m_valid;
    logic [7:0] m_data;

    always #5 clk = ~clk;

    uart_rx #(
        .CLK_FRQ    (CLK_FRQ),
        .BAUD_RATE  (BAUD_RATE),
        .OVERSAMPLE (16)
    ) dut (
        .clk       (clk),
        .areset_n  (areset_n),
        .data_in   (data_in),
        .data_out  (data_out),
        .rx_valid  (rx_valid),
        .rx_ack    (rx_ack),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    task automatic chk(input string tag, input string what,
                       input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk(tag, "data_out",  data_out,  8'h00);
        chk(tag, "rx_valid",  rx_valid,  1'b0);
        chk(tag, "rx_busy",   rx_busy,   1'b0);
        chk(tag, "frame_err", frame_err, 1'b0);
        chk(tag, "overrun",   overrun,   1'b0);
    endtask

    // One-clock ack; effective only if a byte is pending.
    task automatic ack_pulse(input string tag);
        rx_ack = 1'b1;
        @(posedge clk); #1;
        rx_ack = 1'b0;
        m_valid = 1'b0;
        chk(tag, "rx_valid", rx_valid, m_valid);
    endtask

    // Drive one 8N1 frame. Inverts the line for clocks [g0, g0+glen),
    // optionally acks on the decision clock, optionally aborts with reset.
    task automatic send_frame(input logic [7:0] b, input logic stop_lvl,
                              input bit ack_dec, input int g0, input int glen,
                              input int abort_c, input string tag);
        logic exp_fe;
        logic exp_ov;
        logic lvl;
        int   bitn;
        int   stray;
        exp_fe = 1'b0;
        exp_ov = 1'b0;
        stray  = 0;
        for (int c = 0; c < 10 * BITCLK; c++) begin
            bitn = c / BITCLK;
            if (bitn == 0)      lvl = 1'b0;
            else if (bitn == 9) lvl = stop_lvl;
            else                lvl = b[bitn-1];
            if (c >= g0 && c < g0 + glen) lvl = ~lvl;
            data_in = lvl;
            if (c == abort_c) begin
                areset_n = 1'b0;
                data_in  = 1'b1;
                #2;
                chk_reset_outputs({tag, "_rst"});
                m_valid = 1'b0;
                m_data  = 8'h00;
                repeat (3) @(posedge clk);
                #1;
                areset_n = 1'b1;
                break;
            end
            if (c == DEC_C) begin
                rx_ack = ack_dec;
                if (stop_lvl) begin
                    if (m_valid && !ack_dec) begin
                        exp_ov = 1'b1;
                    end else begin
                        m_data  = b;
                        m_valid = 1'b1;
                    end
                end else begin
                    exp_fe = 1'b1;
                    if (ack_dec) m_valid = 1'b0;
                end
            end
            @(posedge clk); #1;
            rx_ack = 1'b0;
            if (c == 1) chk(tag, "busy_before_detect", rx_busy, 1'b0);
            if (c == 2) chk(tag, "busy_after_detect",  rx_busy, 1'b1);
            if (c == DEC_C - 1) begin
                chk(tag, "valid_before_decision", rx_valid, m_valid);
                chk(tag, "busy_before_decision",  rx_busy,  1'b1);
            end
            if (c == DEC_C) begin
                chk(tag, "rx_valid",  rx_valid,  m_valid);
                chk(tag, "data_out",  data_out,  m_data);
                chk(tag, "frame_err", frame_err, exp_fe);
                chk(tag, "overrun",   overrun,   exp_ov);
                chk(tag, "busy_after_decision", rx_busy, 1'b0);
            end else if (frame_err || overrun) begin
                stray++;
            end
        end
        chk(tag, "stray_pulses", stray, 0);
        data_in = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        int         g_stray;
        logic [7:0] rb;
        logic       rstop;
        bit         rack;

        m_valid  = 1'b0;
        m_data   = 8'h00;
        areset_n = 1'b0;
        data_in  = 1'b1;
        rx_ack   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        areset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Clean frame, latency checked inside.
        send_frame(8'hA5, 1'b1, 1'b0, -1, 0, -1, "a5");
        ack_pulse("ack_a5");
        ack_pulse("ack_ignored");

        // Short low glitch in idle: false start, nothing reported.
        g_stray = 0;
        for (int c = 0; c < 500; c++) begin
            data_in = (c < 4 * DIV) ? 1'b0 : 1'b1;
            @(posedge clk); #1;
            if (c == 2)           chk("glitch", "busy_detect", rx_busy, 1'b1);
            if (c == FALSE_C - 1) chk("glitch", "busy_before_reject", rx_busy, 1'b1);
            if (c == FALSE_C)     chk("glitch", "busy_after_reject", rx_busy, 1'b0);
            if (rx_valid || frame_err || overrun) g_stray++;
        end
        chk("glitch", "stray_outputs", g_stray, 0);
        chk("glitch", "busy_end", rx_busy, 1'b0);

        // Low stop bit: framing error, previous byte kept.
        send_frame(8'h3C, 1'b0, 1'b0, -1, 0, -1, "3c_ferr");

        // Back-to-back without ack: second byte overruns.
        send_frame(8'h11, 1'b1, 1'b0, -1, 0, -1, "b2b_11");
        send_frame(8'h22, 1'b1, 1'b0, -1, 0, -1, "b2b_22_ovr");
        ack_pulse("ack_b2b");

        // Ack coincident with the second decision: new byte, no overrun.
        send_frame(8'h11, 1'b1, 1'b0, -1, 0, -1, "ack_11");
        send_frame(8'h22, 1'b1, 1'b1, -1, 0, -1, "ack_22");
        ack_pulse("ack_22_clear");

        // Invert only the ph=8 sample of data bit 7 (tick 136).
        send_frame(8'h81, 1'b1, 1'b0, 3 + 136 * DIV - 13, 18, -1, "81_glitch");
        ack_pulse("ack_81");

        // Reset during data bit 4, then a clean frame.
        send_frame(8'hC3, 1'b1, 1'b0, -1, 0, 5 * BITCLK + 100, "abort");
        send_frame(8'h5A, 1'b1, 1'b0, -1, 0, -1, "5a");
        ack_pulse("ack_5a");

        // Loopback patterns.
        send_frame(8'h00, 1'b1, 1'b0, -1, 0, -1, "lb_00");
        ack_pulse("ack_00");
        send_frame(8'hFF, 1'b1, 1'b0, -1, 0, -1, "lb_ff");
        ack_pulse("ack_ff");
        send_frame(8'h55, 1'b1, 1'b0, -1, 0, -1, "lb_55");

        // Random bytes, stop levels and decision-time acks.
        for (int i = 0; i < 3; i++) begin
            rb    = 8'($urandom);
            rstop = ($urandom_range(0, 3) != 0);
            rack  = 1'($urandom_range(0, 1));
            send_frame(rb, rstop, rack, -1, 0, -1, $sformatf("rand%0d", i));
        end
        ack_pulse("ack_final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_uart_rx
`default_nettype wire
